// File: rtl/fetch_align_queue.sv
// Instruction fetch/align queue: word fetches from memory, byte FIFO, 16-bit instructions at any byte PC.
// Optional store snooping (self-modifying code refetch) is enabled by defining FETCH_SNOOP_EN.
module fetch_align_queue #(
  parameter int          DEPTH_W  = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_ren,
  output logic [14:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        snoop_wen,
  input  logic [15:0] snoop_waddr
);
  localparam int QBYTES = 2 * DEPTH_W;
  localparam int PW     = (QBYTES > 1) ? $clog2(QBYTES) : 1;
  localparam int CW     = $clog2(QBYTES + 1);
  localparam int OW     = CW + 1;

  logic [14:0]   fpc;
  logic [15:0]   head_pc;
  logic [CW-1:0] count;
  logic          inflight;
  logic          skip_first;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [7:0]    fifo_mem [QBYTES];

  logic          flush;
  logic [15:0]   flush_pc;
  logic          hold_out;
  logic [OW-1:0] occ;
  logic          can_issue;
  logic          pop;
  logic          push_one;
  logic          push_two;
  logic [1:0]    push_n;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_nx;
  logic [PW-1:0] wr_nx;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= QBYTES) s = s - QBYTES;
    return PW'(s);
  endfunction

`ifdef FETCH_SNOOP_EN
  // Tracked bytes are head_pc .. head_pc+tracked-1: buffered bytes followed by the in-flight word.
  logic [15:0] tracked;
  logic [15:0] off0;
  logic [15:0] off1;
  logic        snoop_hit;

  always_comb begin
    tracked = 16'(count);
    if (inflight) tracked = tracked + (skip_first ? 16'd1 : 16'd2);
    off0      = snoop_waddr - head_pc;
    off1      = snoop_waddr + 16'd1 - head_pc;
    snoop_hit = snoop_wen && ((off0 < tracked) || (off1 < tracked));
  end

  assign flush    = redirect_valid || snoop_hit;
  assign flush_pc = redirect_valid ? redirect_pc : head_pc;
  assign hold_out = snoop_hit;
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_wen, snoop_waddr};
  assign flush        = redirect_valid;
  assign flush_pc     = redirect_pc;
  assign hold_out     = 1'b0;
`endif

  // Reserve room for the outstanding response before issuing another word.
  assign occ       = OW'(count) + (inflight ? OW'(2) : OW'(0));
  assign can_issue = (occ + OW'(2)) <= OW'(QBYTES);
  assign mem_ren   = rst_n && can_issue && !flush;
  assign mem_raddr = fpc;

  assign rd_nx     = ptr_add(rd_ptr, 1);
  assign out_valid = (count >= CW'(2)) && !hold_out;
  assign out_instr = {fifo_mem[rd_ptr], fifo_mem[rd_nx]};
  assign out_pc    = head_pc;

  assign pop      = out_valid && out_ready;
  assign push_one = inflight && skip_first;
  assign push_two = inflight && !skip_first;
  assign wr_nx    = ptr_add(wr_ptr, 1);

  always_comb begin
    push_n = 2'd0;
    if (push_two)      push_n = 2'd2;
    else if (push_one) push_n = 2'd1;
    count_next = CW'(OW'(count) + OW'(push_n) - (pop ? OW'(2) : OW'(0)));
  end

  // Byte storage carries no reset; only count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!flush && inflight) begin
      if (skip_first) begin
        fifo_mem[wr_ptr] <= mem_rdata[7:0];
      end else begin
        fifo_mem[wr_ptr] <= mem_rdata[15:8];
        fifo_mem[wr_nx]  <= mem_rdata[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc        <= RESET_PC[15:1];
      head_pc    <= RESET_PC;
      skip_first <= RESET_PC[0];
      count      <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (flush) begin
      // The response for last cycle's issue (if any) is dropped here and inflight clears.
      fpc        <= flush_pc[15:1];
      head_pc    <= flush_pc;
      skip_first <= flush_pc[0];
      count      <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (mem_ren) fpc <= fpc + 15'd1;
      inflight <= mem_ren;
      if (push_one) skip_first <= 1'b0;
      count  <= count_next;
      wr_ptr <= ptr_add(wr_ptr, int'(push_n));
      if (pop) begin
        rd_ptr  <= ptr_add(rd_ptr, 2);
        head_pc <= head_pc + 16'd2;
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Self-checking bench for fetch_align_queue: vector tables, directed corner sequences and a
// randomized run against a byte-addressed memory reference; define FETCH_SNOOP_EN to add the snoop test.
`timescale 1ns/1ps
module tb_fetch_align_queue;
  localparam int          DEPTH_W  = 4;
  localparam int          QBYTES   = 2 * DEPTH_W;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        snoop_wen = 1'b0;
  logic [15:0] snoop_waddr = 16'h0000;

  fetch_align_queue #(.DEPTH_W(DEPTH_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .snoop_wen(snoop_wen), .snoop_waddr(snoop_waddr)
  );

  always #5 clk = ~clk;

  // Word-organised instruction memory; read data appears one cycle after the request.
  logic [15:0] mem [0:32767];
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_raddr] : 16'hDEAD;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the instruction stream is simply the memory bytes at pc, pc+1, pc+2, ...
  // restarting at each redirect; byte availability follows the issue/return timing rules.
  logic [15:0] m_head;
  logic [14:0] m_fpc;
  int          m_count;
  bit          m_infl;
  bit          m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [15:0] a);
    logic [15:0] w;
    w = mem[a[15:1]];
    return a[0] ? w[7:0] : w[15:8];
  endfunction

  function automatic logic [15:0] minstr(input logic [15:0] pc);
    return {mbyte(pc), mbyte(pc + 16'd1)};
  endfunction

  task automatic model_reset();
    m_head  = RESET_PC;
    m_fpc   = RESET_PC[15:1];
    m_skip  = RESET_PC[0];
    m_count = 0;
    m_infl  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, compare, then advance the model at posedge.
  task automatic step(input logic rdy, input logic rv, input logic [15:0] rpc,
                      input logic sw, input logic [15:0] swa, input logic flush_exp,
                      output logic s_valid, output logic [15:0] s_pc, output logic [15:0] s_instr,
                      output logic s_ren, output logic [14:0] s_raddr);
    logic        e_valid;
    logic        e_ren;
    logic        e_flush;
    logic [15:0] target;
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    snoop_wen      = sw;
    snoop_waddr    = swa;
    #1;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_ren   = mem_ren;
    s_raddr = mem_raddr;
    e_flush = rv || flush_exp;
    e_valid = (m_count >= 2) && !flush_exp;
    e_ren   = !e_flush && (m_count + 2 * int'(m_infl) + 2 <= QBYTES);
    check("out_valid", s_valid, e_valid);
    if (e_valid) begin
      check("out_pc", s_pc, m_head);
      check("out_instr", s_instr, minstr(m_head));
    end
    check("mem_ren", s_ren, e_ren);
    if (e_ren) check("mem_raddr", s_raddr, m_fpc);
    @(posedge clk);
    if (e_flush) begin
      target  = rv ? rpc : m_head;
      m_head  = target;
      m_fpc   = target[15:1];
      m_skip  = target[0];
      m_count = 0;
      m_infl  = 1'b0;
    end else begin
      if (m_infl) begin
        m_count = m_count + (m_skip ? 1 : 2);
        m_skip  = 1'b0;
      end
      if (e_valid && rdy) begin
        m_count = m_count - 2;
        m_head  = m_head + 16'd2;
      end
      if (e_ren) m_fpc = m_fpc + 15'd1;
      m_infl = e_ren;
    end
  endtask

  task automatic idle_step(input logic rdy, output logic s_valid, output logic s_ren);
    logic [15:0] p;
    logic [15:0] i;
    logic [14:0] a;
    step(rdy, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, s_valid, p, i, s_ren, a);
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    logic        v;
    logic        r;
    logic [15:0] p;
    logic [15:0] i;
    logic [14:0] a;
    step(1'b1, 1'b1, pc, 1'b0, 16'h0, 1'b0, v, p, i, r, a);
  endtask

  // Run with out_ready high until an instruction is taken; bounded.
  task automatic wait_pop(input string tag, input logic [15:0] pc, input logic [15:0] ins);
    logic        v;
    logic        r;
    logic [15:0] p;
    logic [15:0] i;
    logic [14:0] a;
    bit          got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, v, p, i, r, a);
      if (v) begin
        got = 1'b1;
        check({tag, " pc"}, p, pc);
        check({tag, " instr"}, i, ins);
        $display("[%s] instr %h @ %h", tag, i, p);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no out_valid expected pc %h within 20 cycles", tag, pc);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic        e_ren;
    logic [14:0] e_raddr;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vecs(input int lo, input int hi);
    logic        v;
    logic        r;
    logic [15:0] p;
    logic [15:0] i;
    logic [14:0] a;
    for (int k = lo; k <= hi; k++) begin
      step(vecs[k].rdy, vecs[k].rv, vecs[k].rpc, 1'b0, 16'h0, 1'b0, v, p, i, r, a);
      $display("vec %0d: valid=%b pc=%h instr=%h ren=%b raddr=%h", k, v, p, i, r, a);
      check($sformatf("vec%0d valid", k), v, vecs[k].e_valid);
      if (vecs[k].e_valid) begin
        check($sformatf("vec%0d pc", k), p, vecs[k].e_pc);
        check($sformatf("vec%0d instr", k), i, vecs[k].e_instr);
      end
      check($sformatf("vec%0d ren", k), r, vecs[k].e_ren);
      if (vecs[k].e_ren) check($sformatf("vec%0d raddr", k), a, vecs[k].e_raddr);
    end
  endtask

  initial begin
    logic v;
    logic r;
    int   nreads;

    //                rdy  rv   rpc       valid pc        instr     ren   raddr
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 15'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 15'h0001};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1234, 1'b1, 15'h0002};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h5678, 1'b1, 15'h0003};
    // After a redirect to odd PC 0003: word 1 gives only its low byte.
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 15'h0001};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 15'h0002};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 15'h0003};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'hBBCC, 1'b1, 15'h0004};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'hDDEE, 1'b1, 15'h0005};

    for (int w = 0; w < 32768; w++) mem[w] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset mem_ren", mem_ren, 1'b0);
    release_reset();

    // Even-PC start after reset, then odd-PC redirect
    run_vecs(0, 3);
    redirect_to(16'h0003);
    mem[1] = 16'hAABB;
    mem[2] = 16'hCCDD;
    mem[3] = 16'hEEFF;
    run_vecs(4, 8);

    // Redirect right after an issue: that response must be dropped
    redirect_to(16'h0010);
    idle_step(1'b1, v, r);
    check("issue to 0010", r, 1'b1);
    redirect_to(16'h0040);
    wait_pop("redir", 16'h0040, minstr(16'h0040));
    wait_pop("redir", 16'h0042, minstr(16'h0042));

    // Address wrap FFFE -> 0000
    redirect_to(16'hFFFE);
    mem[15'h7FFF] = 16'h1111;
    mem[0]        = 16'h2222;
    wait_pop("wrap", 16'hFFFE, 16'h1111);
    wait_pop("wrap", 16'h0000, 16'h2222);
    redirect_to(16'hFFFF);
    wait_pop("wrap odd", 16'hFFFF, minstr(16'hFFFF));

    // Asynchronous reset mid-stream (count=4, one read in flight)
    rst_n = 1'b0;
    model_reset();
    release_reset();
    repeat (3) idle_step(1'b0, v, r);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset mem_ren", mem_ren, 1'b0);
    model_reset();
    release_reset();

    // Back-pressure from reset: reads stop at QBYTES/2, order preserved on release
    nreads = 0;
    for (int k = 0; k < 12; k++) begin
      idle_step(1'b0, v, r);
      if (r) nreads++;
    end
    check("backpressure reads", nreads, QBYTES / 2);
    check("backpressure valid", v, 1'b1);
    for (int k = 0; k < 6; k++)
      wait_pop("bp", 16'(2 * k), minstr(16'(2 * k)));

    // Randomized run against the reference
    for (int k = 0; k < 4000; k++) begin
      logic        rdy;
      logic        rv;
      logic [15:0] rpc;
      logic [15:0] p;
      logic [15:0] i;
      logic [14:0] a;
      rdy = (k % 500 < 60) ? 1'b0 : ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 39) == 0);
      rpc = 16'($urandom);
      step(rdy, rv, rpc, 1'b0, 16'h0, 1'b0, v, p, i, r, a);
    end

`ifdef FETCH_SNOOP_EN
    // Store into a buffered byte: flush and refetch from head_pc
    redirect_to(16'h0008);
    repeat (8) idle_step(1'b0, v, r);
    mem[5] = 16'h5A5A;
    begin
      logic [15:0] p;
      logic [15:0] i;
      logic [14:0] a;
      step(1'b1, 1'b0, 16'h0, 1'b1, 16'h000A, 1'b1, v, p, i, r, a);
    end
    wait_pop("snoop", 16'h0008, minstr(16'h0008));
    wait_pop("snoop", 16'h000A, 16'h5A5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
